pe_array: RTL and testbench
===========================

Name: pe_array

Overview:
- Multi-lane successor to the single butterfly PE: NUM_LANES independent butterfly lanes share one control stream.
- Carries the operating mode with each beat through the pipeline, so NTT/INTT/CWM/ADDSUB/COMP/DECOMP beats may be issued back-to-back with no flush.
- Adds valid/ready backpressure on both sides and a drain indicator.
- Sits between the polynomial-arithmetic controller/coefficient memories and the write-back path.

Parameters:
- NUM_LANES, 4, number of parallel butterfly lanes (>=1).
- Q, 3329, modulus; all coefficient inputs are expected in [0, Q-1].
- COEFF_W, 12, coefficient width in bits (must satisfy 2^COEFF_W > Q).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- valid_i  in  1  input beat valid
- ready_o  out  1  array can accept a beat this cycle
- mode_i  in  pe_mode_e  mode for this beat; sampled with the beat
- a_i  in  NUM_LANES*COEFF_W  lane a operands, lane k at bits [k*COEFF_W +: COEFF_W]
- b_i  in  NUM_LANES*COEFF_W  lane b operands
- w_i  in  NUM_LANES*COEFF_W  per-lane twiddle/scale
- valid_o  out  1  output beat valid
- ready_i  in  1  downstream accepts output
- u_o  out  NUM_LANES*COEFF_W  lane u results
- v_o  out  NUM_LANES*COEFF_W  lane v results
- mode_o  out  pe_mode_e  mode of the beat on the outputs
- busy_o  out  1  any pipeline stage holds a valid beat

Behaviour:
- Per-lane arithmetic, all mod Q, outputs in [0, Q-1]:
  - NTT/CWM: t=b*w; u=a+t; v=a-t.
  - INTT: u=(a+b)/2, where an odd sum has Q added before the halving; v=(a-b)*w.
  - ADDSUB: u=a+b; v=a-b; w is ignored.
  - COMP/DECOMP: u=a passthrough; v=b*w.
- Pipeline: 3 stages, with fixed latency 3 cycles from accept to valid_o when not stalled.
  - S1: operand select, INTT pre-add/pre-sub.
  - S2: modular multiply.
  - S3: final add/sub and div2.
- Mode travels in a per-stage register alongside the data. A mode change between consecutive beats requires no bubble.
- Handshake:
  - Accept occurs when valid_i&&ready_o.
  - Output transfer occurs when valid_o&&ready_i.
  - Global advance enable: en = !valid_o || ready_i; ready_o = en.
  - When en=0, all stages hold data, valid and mode unchanged.
  - valid_i is ignored when ready_o=0; the upstream must hold its beat.
  - Bubbles are not compacted; throughput is 1 beat/cycle when ready_i=1.
- Output registers hold value while valid_o=1 and ready_i=0. u_o/v_o/mode_o are don't-care when valid_o=0.
- busy_o = OR of the stage valid bits. The controller waits for busy_o=0 before reusing result memory.
- Reset: all stage valid bits clear next edge; valid_o=0, busy_o=0, ready_o=1, u_o=v_o=0, mode_o=PE_MODE_NTT. A reset mid-stream drops all in-flight beats silently.
- Inputs >= Q: result undefined, except as covered by the optional feature.
- Simultaneous accept and output transfer in one cycle is legal and sustains full throughput.

Optional Feature:
- Macro: PE_ARRAY_RANGE_CHECK_EN.
- Defined:
  - Adds output port range_err_o (1 bit), a sticky flag.
  - range_err_o is set the cycle after an accepted beat has any lane a_i/b_i/w_i >= Q.
  - ADDSUB ignores w for this check.
  - Cleared only by rst; reset value 0. Datapath results are unaffected.
- Undefined: no port and no comparator logic; out-of-range input gives an undefined result.

Decomposition:
- poly_arith_pkg: reuse pe_mode_e and coeff_t; add the Q default constant and a lane-vector typedef (coeff_t [NUM_LANES-1:0]) if absent.
- Sub-module pe_mod_mul:
  - One-cycle registered Barrett multiplier with a stall enable.
  - One instance per lane in S2.
- Lane add/sub/div2 logic is inline.

Test Plan:
- NTT, lane0 a=10,b=2,w=5; other lanes zero -> lane0 u=20,v=0; other lanes u=v=0; valid_o exactly 3 cycles after accept.
- Back-to-back, no gap, all lanes 3328/3328/3328:
  - NTT beat -> u=0,v=3327, mode_o=NTT.
  - INTT beat on the next cycle -> u=3328,v=0, mode_o=INTT.
- INTT a=1,b=0,w=1 -> u=1665,v=1.
- ADDSUB a=1000,b=2500 -> u=171,v=1829.
- Backpressure: issue 6 ADDSUB beats with a=k,b=0 (k=0..5); hold ready_i=0 for 5 cycles mid-stream.
  - ready_o follows the stall.
  - All 6 outputs (u=k) arrive in order, with no loss or duplication.
- Reset mid-stream: with 2 beats in flight, pulse rst for 1 cycle -> valid_o=0 and busy_o=0 next cycle; no stale beat is emitted afterward.
- With PE_ARRAY_RANGE_CHECK_EN: issue a beat with b=3329 -> range_err_o=1 from the next cycle and it stays set until rst.

Source files
------------

// File: rtl/poly_arith_pkg.sv
// Shared types and defaults for the polynomial-arithmetic datapath:
// butterfly modes, coefficient type and the default modulus/width.
package poly_arith_pkg;

   localparam int unsigned PE_Q         = 3329;
   localparam int unsigned PE_COEFF_W   = 12;
   localparam int unsigned PE_NUM_LANES = 4;

   typedef enum logic [2:0] {
      PE_MODE_NTT    = 3'd0,
      PE_MODE_INTT   = 3'd1,
      PE_MODE_CWM    = 3'd2,
      PE_MODE_ADDSUB = 3'd3,
      PE_MODE_COMP   = 3'd4,
      PE_MODE_DECOMP = 3'd5
   } pe_mode_e;

   typedef logic [PE_COEFF_W-1:0] coeff_t;
   typedef coeff_t [PE_NUM_LANES-1:0] coeff_vec_t;

endpackage

// File: rtl/pe_mod_mul.sv
// One-cycle registered Barrett modular multiplier, o_p = (i_x * i_y) mod Q,
// holding its result while i_en is low.
module pe_mod_mul
   import poly_arith_pkg::*;
#(
   parameter int unsigned Q       = PE_Q,
   parameter int unsigned COEFF_W = PE_COEFF_W
) (
   input  logic               clk,
   input  logic               i_en,
   input  logic [COEFF_W-1:0] i_x,
   input  logic [COEFF_W-1:0] i_y,
   output logic [COEFF_W-1:0] o_p
);

   localparam int unsigned    K   = 2 * COEFF_W;
   localparam int unsigned    MW  = K + 1;
   localparam int unsigned    EW  = K + MW;
   localparam longint unsigned M_L = (64'd1 << K) / 64'(Q);
   localparam logic [MW-1:0]  M   = MW'(M_L);
   localparam logic [K-1:0]   QK  = K'(Q);
   localparam logic [K-1:0]   Q2K = K'(2 * Q);

   logic [K-1:0]       w_prod;
   logic [EW-1:0]      w_est;
   logic [K-1:0]       w_qhat;
   logic [K-1:0]       w_rem;
   logic [K-1:0]       w_red;
   logic [COEFF_W-1:0] r_p;

   assign w_prod = K'(i_x) * K'(i_y);
   assign w_est  = EW'(w_prod) * EW'(M);
   assign w_qhat = K'(w_est >> K);
   // The quotient estimate undershoots by at most two, so the remainder is below 3Q.
   assign w_rem  = w_prod - w_qhat * QK;

   always_comb begin
      w_red = w_rem;
      if (w_rem >= Q2K) begin
         w_red = w_rem - Q2K;
      end else if (w_rem >= QK) begin
         w_red = w_rem - QK;
      end
   end

   always_ff @(posedge clk) begin
      if (i_en) begin
         r_p <= COEFF_W'(w_red);
      end
   end

   assign o_p = r_p;

endmodule

// File: rtl/pe_array.sv
// NUM_LANES butterfly lanes sharing one 3-stage pipeline with a per-beat mode and
// valid/ready flow control. Optional macro PE_ARRAY_RANGE_CHECK_EN adds range_err_o.
module pe_array
   import poly_arith_pkg::*;
#(
   parameter int unsigned NUM_LANES = PE_NUM_LANES,
   parameter int unsigned Q         = PE_Q,
   parameter int unsigned COEFF_W   = PE_COEFF_W
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         valid_i,
   output logic                         ready_o,
   input  pe_mode_e                     mode_i,
   input  logic [NUM_LANES*COEFF_W-1:0] a_i,
   input  logic [NUM_LANES*COEFF_W-1:0] b_i,
   input  logic [NUM_LANES*COEFF_W-1:0] w_i,
   output logic                         valid_o,
   input  logic                         ready_i,
   output logic [NUM_LANES*COEFF_W-1:0] u_o,
   output logic [NUM_LANES*COEFF_W-1:0] v_o,
   output pe_mode_e                     mode_o,
   output logic                         busy_o
`ifdef PE_ARRAY_RANGE_CHECK_EN
   ,
   output logic                         range_err_o
`endif
);

   localparam int unsigned        LW  = NUM_LANES * COEFF_W;
   localparam logic [COEFF_W-1:0] QC  = COEFF_W'(Q);
   localparam logic [COEFF_W-1:0] ONE = COEFF_W'(1);

   function automatic logic [COEFF_W-1:0] mod_add(input logic [COEFF_W-1:0] x,
                                                  input logic [COEFF_W-1:0] y);
      logic [COEFF_W:0] s;
      s = {1'b0, x} + {1'b0, y};
      if (s >= {1'b0, QC}) begin
         s = s - {1'b0, QC};
      end
      return s[COEFF_W-1:0];
   endfunction

   function automatic logic [COEFF_W-1:0] mod_sub(input logic [COEFF_W-1:0] x,
                                                  input logic [COEFF_W-1:0] y);
      if (x >= y) begin
         return x - y;
      end
      return x + (QC - y);
   endfunction

   // Halving mod Q: an odd residue has Q added first so the shift is exact.
   function automatic logic [COEFF_W-1:0] mod_div2(input logic [COEFF_W-1:0] x);
      logic [COEFF_W:0] s;
      s = {1'b0, x};
      if (x[0]) begin
         s = s + {1'b0, QC};
      end
      return COEFF_W'(s >> 1);
   endfunction

   logic          w_en;
   logic          r_vld_p0;
   logic          r_vld_p1;
   logic          r_vld_p2;
   pe_mode_e      r_mode_p0;
   pe_mode_e      r_mode_p1;
   pe_mode_e      r_mode_p2;
   logic [LW-1:0] r_u_p2;
   logic [LW-1:0] r_v_p2;
   logic [LW-1:0] w_u_nxt;
   logic [LW-1:0] w_v_nxt;

   // A single advance enable freezes every stage when the output is held.
   assign w_en    = !r_vld_p2 || ready_i;
   assign ready_o = w_en;
   assign valid_o = r_vld_p2;
   assign busy_o  = r_vld_p0 || r_vld_p1 || r_vld_p2;
   assign mode_o  = r_mode_p2;
   assign u_o     = r_u_p2;
   assign v_o     = r_v_p2;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_vld_p0  <= 1'b0;
         r_vld_p1  <= 1'b0;
         r_vld_p2  <= 1'b0;
         r_mode_p0 <= PE_MODE_NTT;
         r_mode_p1 <= PE_MODE_NTT;
         r_mode_p2 <= PE_MODE_NTT;
         r_u_p2    <= '0;
         r_v_p2    <= '0;
      end else if (w_en) begin
         r_vld_p0  <= valid_i;
         r_vld_p1  <= r_vld_p0;
         r_vld_p2  <= r_vld_p1;
         r_mode_p0 <= mode_i;
         r_mode_p1 <= r_mode_p0;
         r_mode_p2 <= r_mode_p1;
         r_u_p2    <= w_u_nxt;
         r_v_p2    <= w_v_nxt;
      end
   end

   for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
      logic [COEFF_W-1:0] w_a;
      logic [COEFF_W-1:0] w_b;
      logic [COEFF_W-1:0] w_w;
      logic [COEFF_W-1:0] w_sum;
      logic [COEFF_W-1:0] w_dif;
      logic [COEFF_W-1:0] w_mx;
      logic [COEFF_W-1:0] w_my;
      logic [COEFF_W-1:0] w_c;
      logic [COEFF_W-1:0] w_t_p1;
      logic [COEFF_W-1:0] w_u;
      logic [COEFF_W-1:0] w_v;
      logic [COEFF_W-1:0] r_mx_p0;
      logic [COEFF_W-1:0] r_my_p0;
      logic [COEFF_W-1:0] r_c_p0;
      logic [COEFF_W-1:0] r_c_p1;

      assign w_a   = a_i[k*COEFF_W +: COEFF_W];
      assign w_b   = b_i[k*COEFF_W +: COEFF_W];
      assign w_w   = w_i[k*COEFF_W +: COEFF_W];
      assign w_sum = mod_add(w_a, w_b);
      assign w_dif = mod_sub(w_a, w_b);

      // S1: operand select; ADDSUB routes its difference through the multiplier times one.
      always_comb begin
         w_mx = w_b;
         w_my = w_w;
         w_c  = w_a;
         case (mode_i)
            PE_MODE_INTT: begin
               w_mx = w_dif;
               w_c  = w_sum;
            end
            PE_MODE_ADDSUB: begin
               w_mx = w_dif;
               w_my = ONE;
               w_c  = w_sum;
            end
            default: ;
         endcase
      end

      always_ff @(posedge clk) begin
         if (w_en) begin
            r_mx_p0 <= w_mx;
            r_my_p0 <= w_my;
            r_c_p0  <= w_c;
            r_c_p1  <= r_c_p0;
         end
      end

      // S2: modular multiply.
      pe_mod_mul #(
         .Q       (Q),
         .COEFF_W (COEFF_W)
      ) u_mul (
         .clk  (clk),
         .i_en (w_en),
         .i_x  (r_mx_p0),
         .i_y  (r_my_p0),
         .o_p  (w_t_p1)
      );

      // S3: final butterfly add/sub or INTT halving.
      always_comb begin
         w_u = r_c_p1;
         w_v = w_t_p1;
         case (r_mode_p1)
            PE_MODE_NTT, PE_MODE_CWM: begin
               w_u = mod_add(r_c_p1, w_t_p1);
               w_v = mod_sub(r_c_p1, w_t_p1);
            end
            PE_MODE_INTT: begin
               w_u = mod_div2(r_c_p1);
            end
            default: ;
         endcase
      end

      assign w_u_nxt[k*COEFF_W +: COEFF_W] = w_u;
      assign w_v_nxt[k*COEFF_W +: COEFF_W] = w_v;
   end

`ifdef PE_ARRAY_RANGE_CHECK_EN
   logic w_range_hit;
   logic r_range_err;

   always_comb begin
      w_range_hit = 1'b0;
      for (int k = 0; k < int'(NUM_LANES); k++) begin
         if (a_i[k*COEFF_W +: COEFF_W] >= QC || b_i[k*COEFF_W +: COEFF_W] >= QC) begin
            w_range_hit = 1'b1;
         end
         if (mode_i != PE_MODE_ADDSUB && w_i[k*COEFF_W +: COEFF_W] >= QC) begin
            w_range_hit = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_range_err <= 1'b0;
      end else if (valid_i && w_en && w_range_hit) begin
         r_range_err <= 1'b1;
      end
   end

   assign range_err_o = r_range_err;
`endif

endmodule

// File: tb/tb_pe_array.sv
// Bench for pe_array: directed butterfly vectors, backpressure, mid-stream reset and
// randomized traffic checked against a modular-arithmetic reference and scoreboard.
module tb_pe_array;
   import poly_arith_pkg::*;

   localparam int NL = 4;
   localparam int QQ = 3329;
   localparam int CW = 12;
   localparam int LW = NL * CW;

   logic          clk = 1'b0;
   logic          rst;
   logic          valid_i;
   logic          ready_o;
   pe_mode_e      mode_i;
   logic [LW-1:0] a_i;
   logic [LW-1:0] b_i;
   logic [LW-1:0] w_i;
   logic          valid_o;
   logic          ready_i;
   logic [LW-1:0] u_o;
   logic [LW-1:0] v_o;
   pe_mode_e      mode_o;
   logic          busy_o;
`ifdef PE_ARRAY_RANGE_CHECK_EN
   logic          range_err_o;
`endif

   pe_array #(.NUM_LANES(NL), .Q(QQ), .COEFF_W(CW)) dut (
      .clk     (clk),
      .rst     (rst),
      .valid_i (valid_i),
      .ready_o (ready_o),
      .mode_i  (mode_i),
      .a_i     (a_i),
      .b_i     (b_i),
      .w_i     (w_i),
      .valid_o (valid_o),
      .ready_i (ready_i),
      .u_o     (u_o),
      .v_o     (v_o),
      .mode_o  (mode_o),
      .busy_o  (busy_o)
`ifdef PE_ARRAY_RANGE_CHECK_EN
      ,
      .range_err_o (range_err_o)
`endif
   );

   always #5 clk = ~clk;

   int            tests = 0;
   int            fails = 0;
   logic [LW-1:0] q_u[$];
   logic [LW-1:0] q_v[$];
   pe_mode_e      q_m[$];
   logic [LW-1:0] g_u[$];
   logic [LW-1:0] g_v[$];
   pe_mode_e      g_m[$];
   bit            last_acc = 1'b0;

   function automatic logic [LW-1:0] rep(input int x);
      logic [LW-1:0] r;
      for (int l = 0; l < NL; l++) r[l*CW +: CW] = CW'(x);
      return r;
   endfunction

   function automatic int rv();
      int sel;
      sel = $urandom_range(0, 7);
      if (sel == 0) return 0;
      if (sel == 1) return QQ - 1;
      return $urandom_range(0, QQ - 1);
   endfunction

   // Reference: field arithmetic mod Q; INTT halving is multiplication by the inverse of 2.
   function automatic void model(input pe_mode_e m, input logic [LW-1:0] a, input logic [LW-1:0] b,
                                 input logic [LW-1:0] w, output logic [LW-1:0] u,
                                 output logic [LW-1:0] v);
      int ia, ib, iw, iu, iv;
      for (int l = 0; l < NL; l++) begin
         ia = int'(a[l*CW +: CW]);
         ib = int'(b[l*CW +: CW]);
         iw = int'(w[l*CW +: CW]);
         case (m)
            PE_MODE_NTT, PE_MODE_CWM: begin
               iu = (ia + (ib * iw) % QQ) % QQ;
               iv = (ia - (ib * iw) % QQ + QQ) % QQ;
            end
            PE_MODE_INTT: begin
               iu = ((ia + ib) * ((QQ + 1) / 2)) % QQ;
               iv = (((ia - ib + QQ) % QQ) * iw) % QQ;
            end
            PE_MODE_ADDSUB: begin
               iu = (ia + ib) % QQ;
               iv = (ia - ib + QQ) % QQ;
            end
            default: begin
               iu = ia;
               iv = (ib * iw) % QQ;
            end
         endcase
         u[l*CW +: CW] = CW'(iu);
         v[l*CW +: CW] = CW'(iv);
      end
   endfunction

   task automatic check(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One clock: record accepts into the model queue and score output transfers.
   task automatic cycle();
      logic [LW-1:0] eu, ev;
      #1;
      last_acc = 1'b0;
      if (!rst) begin
         if (valid_i && ready_o) begin
            model(mode_i, a_i, b_i, w_i, eu, ev);
            q_u.push_back(eu);
            q_v.push_back(ev);
            q_m.push_back(mode_i);
            last_acc = 1'b1;
         end
         if (valid_o && ready_i) begin
            g_u.push_back(u_o);
            g_v.push_back(v_o);
            g_m.push_back(mode_o);
            if (q_u.size() == 0) begin
               check("sb_extra_beat", LW'(q_u.size()), LW'(1));
            end else begin
               check("sb_u", u_o, q_u.pop_front());
               check("sb_v", v_o, q_v.pop_front());
               check("sb_mode", LW'(mode_o), LW'(q_m.pop_front()));
            end
         end
      end
      @(posedge clk);
      #1;
      if (rst) begin
         q_u.delete();
         q_v.delete();
         q_m.delete();
      end
   endtask

   task automatic send(input pe_mode_e m, input logic [LW-1:0] a, input logic [LW-1:0] b,
                       input logic [LW-1:0] w);
      mode_i  = m;
      a_i     = a;
      b_i     = b;
      w_i     = w;
      valid_i = 1'b1;
      cycle();
      valid_i = 1'b0;
   endtask

   task automatic drain(input int maxc);
      int n;
      n       = 0;
      valid_i = 1'b0;
      ready_i = 1'b1;
      while (q_u.size() > 0 && n < maxc) begin
         cycle();
         n++;
      end
      check("drain_empty", LW'(q_u.size()), LW'(0));
   endtask

   task automatic clear_got();
      g_u.delete();
      g_v.delete();
      g_m.delete();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed no finish, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [LW-1:0] ea, eb, ew, eu;
      int            lat, k, n;

      rst     = 1'b1;
      valid_i = 1'b0;
      ready_i = 1'b1;
      mode_i  = PE_MODE_NTT;
      a_i     = '0;
      b_i     = '0;
      w_i     = '0;
      repeat (3) cycle();
      rst = 1'b0;
      check("rst_valid_o", LW'(valid_o), LW'(0));
      check("rst_busy_o", LW'(busy_o), LW'(0));
      check("rst_ready_o", LW'(ready_o), LW'(1));
      check("rst_u_o", u_o, '0);
      check("rst_v_o", v_o, '0);
      check("rst_mode_o", LW'(mode_o), LW'(PE_MODE_NTT));
`ifdef PE_ARRAY_RANGE_CHECK_EN
      check("rst_range_err", LW'(range_err_o), LW'(0));
`endif

      // NTT on lane 0 only, with latency measurement.
      clear_got();
      ea = '0; eb = '0; ew = '0;
      ea[CW-1:0] = CW'(10);
      eb[CW-1:0] = CW'(2);
      ew[CW-1:0] = CW'(5);
      send(PE_MODE_NTT, ea, eb, ew);
      lat = 0;
      while (g_u.size() == 0 && lat < 10) begin
         cycle();
         lat++;
      end
      check("ntt_latency", LW'(lat), LW'(3));
      eu = '0;
      eu[CW-1:0] = CW'(20);
      check("ntt_lane0_u", g_u[0], eu);
      check("ntt_lane0_v", g_v[0], '0);
      check("ntt_mode", LW'(g_m[0]), LW'(PE_MODE_NTT));

      // Back-to-back NTT then INTT with all operands at Q-1.
      clear_got();
      mode_i  = PE_MODE_NTT;
      a_i     = rep(3328);
      b_i     = rep(3328);
      w_i     = rep(3328);
      valid_i = 1'b1;
      cycle();
      mode_i = PE_MODE_INTT;
      cycle();
      drain(20);
      check("b2b_ntt_u", g_u[0], rep(0));
      check("b2b_ntt_v", g_v[0], rep(3327));
      check("b2b_ntt_mode", LW'(g_m[0]), LW'(PE_MODE_NTT));
      check("b2b_intt_u", g_u[1], rep(3328));
      check("b2b_intt_v", g_v[1], rep(0));
      check("b2b_intt_mode", LW'(g_m[1]), LW'(PE_MODE_INTT));

      // INTT odd-sum halving and ADDSUB wraparound.
      clear_got();
      send(PE_MODE_INTT, rep(1), rep(0), rep(1));
      send(PE_MODE_ADDSUB, rep(1000), rep(2500), rep($urandom_range(0, QQ - 1)));
      drain(20);
      check("intt_u", g_u[0], rep(1665));
      check("intt_v", g_v[0], rep(1));
      check("addsub_u", g_u[1], rep(171));
      check("addsub_v", g_v[1], rep(1829));

      // Backpressure: ready_i low for five cycles in the middle of six beats.
      clear_got();
      k       = 0;
      n       = 0;
      mode_i  = PE_MODE_ADDSUB;
      b_i     = rep(0);
      w_i     = rep($urandom_range(0, QQ - 1));
      valid_i = 1'b1;
      while (k < 6 && n < 60) begin
         if (n == 7) begin
            check("bp_stall_ready_o", LW'(ready_o), LW'(0));
            check("bp_stall_valid_o", LW'(valid_o), LW'(1));
            check("bp_stall_u_o", u_o, rep(0));
            check("bp_stall_busy_o", LW'(busy_o), LW'(1));
         end
         a_i     = rep(k);
         ready_i = !(n >= 3 && n < 8);
         cycle();
         if (last_acc) k++;
         n++;
      end
      drain(40);
      check("bp_count", LW'(g_u.size()), LW'(6));
      for (int i = 0; i < 6; i++) check("bp_order_u", g_u[i], rep(i));

      // Reset with two beats in flight drops them silently.
      clear_got();
      send(PE_MODE_ADDSUB, rep(7), rep(0), rep(0));
      send(PE_MODE_ADDSUB, rep(8), rep(0), rep(0));
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      check("midrst_valid_o", LW'(valid_o), LW'(0));
      check("midrst_busy_o", LW'(busy_o), LW'(0));
      repeat (6) cycle();
      check("midrst_no_stale", LW'(g_u.size()), LW'(0));

      // Randomized traffic with random stalls; the upstream holds a beat until accepted.
      valid_i = 1'b0;
      for (int it = 0; it < 400; it++) begin
         if (!valid_i || last_acc) begin
            valid_i = ($urandom_range(0, 3) != 0);
            mode_i  = pe_mode_e'(3'($urandom_range(0, 5)));
            for (int l = 0; l < NL; l++) begin
               a_i[l*CW +: CW] = CW'(rv());
               b_i[l*CW +: CW] = CW'(rv());
               w_i[l*CW +: CW] = CW'(rv());
            end
         end
         ready_i = ($urandom_range(0, 3) != 0);
         cycle();
      end
      drain(50);

`ifdef PE_ARRAY_RANGE_CHECK_EN
      send(PE_MODE_ADDSUB, rep(0), rep(0), rep(4000));
      check("range_addsub_w_ignored", LW'(range_err_o), LW'(0));
      eb = '0;
      eb[CW +: CW] = CW'(3329);
      send(PE_MODE_NTT, rep(0), eb, rep(0));
      check("range_set", LW'(range_err_o), LW'(1));
      drain(20);
      repeat (3) cycle();
      check("range_sticky", LW'(range_err_o), LW'(1));
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      check("range_rst_clear", LW'(range_err_o), LW'(0));
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
